register_file_legv8: RTL and testbench
======================================

Name: register_file_legv8

Overview:
- Operand source for the LEGv8 datapath; sits directly upstream of the 64-bit ALU.
- Holds 32 x 64-bit general registers X0..X31. X31 is XZR and always reads zero.
- Two combinational read ports drive the ALU A and B operands; one synchronous write port takes write-back data.
- Also contains the NZCV status latch, loaded from the ALU status vector on flag-setting instructions.
- A sequential clear engine zeroes X0..X30 one register per cycle on command.

Parameters:
- N, 64, register width in bits.
- CLR_START, 0, first register index cleared by the clear engine.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- SA  input  5  read-port A register index.
- SB  input  5  read-port B register index.
- A  output  N  read-port A data (to ALU A).
- B  output  N  read-port B data (to ALU B).
- DA  input  5  write register index.
- D  input  N  write data.
- W  input  1  write enable.
- SL  input  1  status load enable.
- status_in  input  4  {V,C,N,Z} from the ALU.
- status_out  output  4  latched {V,C,N,Z}.
- clr  input  1  start clear sequence (single-cycle pulse or level).
- busy  output  1  high while the clear sequence runs.

Behaviour:
- Reset (asynchronous, active-high): all 31 storage registers = 0, status_out = 4'b0000, busy = 0, FSM = IDLE, clear counter = 0.
- Reads are combinational, zero latency: A = (SA==31) ? 0 : reg[SA]. B likewise from SB.
- Without the optional feature, a read of the index being written this cycle returns the old value.
- Write: on the rising edge, if W && !busy && DA!=31, then reg[DA] <= D.
  - A write to index 31 is discarded.
  - W while busy is ignored (dropped, not queued).
- Status latch: on the rising edge, if SL, status_out <= status_in; otherwise it holds. SL is honoured even while busy.
- Clear FSM states:
  - IDLE: busy=0. clr=1 -> CLEAR, counter <= CLR_START.
  - CLEAR: busy=1. Each cycle reg[counter] <= 0 and counter increments. When counter==30, that register is cleared, then the FSM goes to DONE.
  - DONE: busy=0 for one cycle, then IDLE. clr is ignored in DONE.
- Timing with CLR_START=0: clr sampled high at edge 0 gives busy=1 for 31 cycles (edges 1..31 clear X0..X30). busy falls after edge 31.
- clr asserted while in CLEAR is ignored; the sequence does not restart.
- Reads during CLEAR return the current contents (a mix of cleared and uncleared registers). Reads are not stalled.
- Reset mid-CLEAR aborts immediately: all registers = 0, busy = 0, FSM = IDLE.
- CLR_START > 30: the FSM goes IDLE -> DONE with no registers cleared and busy never rises.
- The status latch is not touched by the clear engine.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: when W && !busy && DA!=31 && DA==SA, A = D combinationally in the same cycle. Same rule for B with SB. This gives a write-through register file (write-back to operand with no bubble).
- Undefined: reads return stored contents only; the new value is visible the cycle after the write edge.

Test Plan:
- Reset, then read SA=5, SB=31 -> A=0, B=0. Write W=1 DA=5 D=64'h0123_4567_89AB_CDEF; next cycle SA=5 -> A=64'h0123_4567_89AB_CDEF.
- Write W=1 DA=31 D=64'hFFFF_FFFF_FFFF_FFFF; next cycle SA=31, SB=31 -> A=0, B=0.
- Same-cycle W=1 DA=7 D=64'hAA, SA=7, old X7=64'h11:
  - Bypass undefined: A=64'h11 that cycle, 64'hAA the next.
  - Bypass defined: A=64'hAA that cycle.
- SL=1, status_in=4'b1010 -> status_out=4'b1010 next cycle. SL=0, status_in=4'b0101 -> status_out stays 4'b1010.
- Preload X0=1, X15=2, X30=3, then pulse clr:
  - busy=1 for exactly 31 cycles.
  - W=1 DA=3 D=9 mid-sequence is dropped.
  - Afterwards X0=X15=X30=X3=0.
- Start clr; at cycle 10 assert reset for 1 cycle -> busy=0 immediately, all registers and status_out = 0. Next write DA=2 D=5 -> X2 reads 5.

Source files
------------

// File: rtl/register_file_legv8.sv
// register_file_legv8: 31x64 LEGv8 register file with XZR, NZCV status latch and sequential clear engine
// Ports: clock/reset (async active-high); SA/SB -> A/B combinational reads; DA/D/W synchronous write;
// SL/status_in -> status_out {V,C,N,Z}; clr starts clearing X0..X30, busy high while clearing.
// Optional: define REGFILE_WRITE_BYPASS_EN to forward same-cycle write data to the read ports.
module register_file_legv8 #(
  parameter int N = 64,
  parameter int CLR_START = 0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [4:0]   SA,
  input  logic [4:0]   SB,
  output logic [N-1:0] A,
  output logic [N-1:0] B,
  input  logic [4:0]   DA,
  input  logic [N-1:0] D,
  input  logic         W,
  input  logic         SL,
  input  logic [3:0]   status_in,
  output logic [3:0]   status_out,
  input  logic         clr,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [N-1:0] regs_q [31];
  logic [3:0] status_q;
  logic wr_en;
  assign wr_en = W && !busy && DA != 5'd31;
  assign status_out = status_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      status_q <= '0;
      for (int i = 0; i < 31; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (SL) status_q <= status_in;
      for (int i = 0; i < 31; i++)
        if (busy && cnt_q == 5'(i)) regs_q[i] <= '0;
        else if (wr_en && DA == 5'(i)) regs_q[i] <= D;
    end
  end
  // A start index past X30 has nothing to clear, so skip straight to DONE
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (clr) begin
        state_d = (CLR_START > 30) ? DONE : CLEAR;
        cnt_d = 5'(CLR_START);
      end
      CLEAR: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd30) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb busy = state_q == CLEAR;
`ifdef REGFILE_WRITE_BYPASS_EN
  assign A = (SA == 5'd31) ? '0 : (wr_en && DA == SA) ? D : regs_q[SA];
  assign B = (SB == 5'd31) ? '0 : (wr_en && DA == SB) ? D : regs_q[SB];
`else
  assign A = (SA == 5'd31) ? '0 : regs_q[SA];
  assign B = (SB == 5'd31) ? '0 : regs_q[SB];
`endif
endmodule

// File: tb/tb_register_file_legv8.sv
// tb_register_file_legv8: directed scoreboard bench for register_file_legv8
module tb_register_file_legv8;
  logic clock = 1'b0;
  logic reset, W, SL, clr;
  logic [4:0] SA, SB, DA;
  logic [63:0] A, B, D;
  logic [3:0] status_in, status_out;
  logic busy;
  int checks = 0;
  int errors = 0;
  int cycles;
  typedef struct {
    string tag;
    logic [63:0] exp;
  } sb_t;
  sb_t sb[$];

  register_file_legv8 dut (
    .clock(clock), .reset(reset), .SA(SA), .SB(SB), .A(A), .B(B),
    .DA(DA), .D(D), .W(W), .SL(SL), .status_in(status_in),
    .status_out(status_out), .clr(clr), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ex(input string tag, input logic [63:0] v);
    sb_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic ck(input logic [63:0] obs);
    sb_t e;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h required an entry", obs);
    end else begin
      e = sb.pop_front();
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic wr(input logic [4:0] da, input logic [63:0] d);
    W = 1'b1; DA = da; D = d;
    tick();
    W = 1'b0;
  endtask

  initial begin
    reset = 1'b1; W = 0; SL = 0; clr = 0; SA = 0; SB = 0; DA = 0; D = 0; status_in = 0;
    tick(); tick();
    reset = 1'b0;
    SA = 5; SB = 31;
    ex("reset_A", 0); ex("reset_B", 0); ex("reset_status", 0); ex("reset_busy", 0);
    #1; ck(A); ck(B); ck(status_out); ck(busy);

    wr(5, 64'h0123_4567_89AB_CDEF);
    ex("write_x5", 64'h0123_4567_89AB_CDEF);
    #1; ck(A);

    wr(31, 64'hFFFF_FFFF_FFFF_FFFF);
    SA = 31; SB = 31;
    ex("xzr_A", 0); ex("xzr_B", 0);
    #1; ck(A); ck(B);
    SB = 5;
    ex("x5_kept", 64'h0123_4567_89AB_CDEF);
    #1; ck(B);

    wr(7, 64'h11);
    W = 1; DA = 7; D = 64'hAA; SA = 7; SB = 7;
`ifdef REGFILE_WRITE_BYPASS_EN
    ex("same_cycle_A", 64'hAA); ex("same_cycle_B", 64'hAA);
`else
    ex("same_cycle_A", 64'h11); ex("same_cycle_B", 64'h11);
`endif
    #1; ck(A); ck(B);
    tick();
    W = 0;
    ex("next_cycle_A", 64'hAA);
    #1; ck(A);

    SL = 1; status_in = 4'b1010;
    tick();
    SL = 0; status_in = 4'b0101;
    ex("status_load", 4'b1010);
    #1; ck(status_out);
    tick();
    ex("status_hold", 4'b1010);
    #1; ck(status_out);

    wr(0, 1); wr(15, 2); wr(30, 3); wr(3, 4);
    SA = 0; SB = 15;
    clr = 1;
    tick();
    clr = 0;
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      if (cycles == 10) begin
        ex("mid_clear_x0", 0); ex("mid_clear_x15", 2);
        ck(A); ck(B);
      end
      W = (cycles == 5); DA = 3; D = 9;
      clr = (cycles == 8);
      SL = (cycles == 12); status_in = 4'b0110;
      tick();
    end
    W = 0; clr = 0; SL = 0;
    ex("busy_cycles", 31);
    ck(64'(cycles));
    clr = 1;
    tick();
    clr = 0;
    ex("done_ignores_clr", 0);
    #1; ck(busy);
    SA = 0; SB = 15;
    ex("cleared_x0", 0); ex("cleared_x15", 0);
    #1; ck(A); ck(B);
    SA = 30; SB = 3;
    ex("cleared_x30", 0); ex("dropped_write_x3", 0);
    #1; ck(A); ck(B);
    ex("status_during_busy", 4'b0110);
    ck(status_out);

    wr(20, 7);
    clr = 1;
    tick();
    clr = 0;
    repeat (9) tick();
    ex("busy_before_abort", 1);
    ck(busy);
    reset = 1;
    SA = 20;
    ex("abort_busy", 0); ex("abort_x20", 0); ex("abort_status", 0);
    #1; ck(busy); ck(A); ck(status_out);
    tick();
    reset = 0;
    wr(2, 5);
    SA = 2;
    ex("post_abort_x2", 5); ex("post_abort_busy", 0);
    #1; ck(A); ck(busy);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
